// File: rtl/uart_byte_receiver_if.sv
// Valid/ready byte stream from the UART receiver toward the harness core.
// The receiver drives the master side; the consumer drives data_out_ready.
interface uart_byte_receiver_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  modport master (
    output data_out,
    output data_out_valid,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output data_out_ready
  );
endinterface

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with mid-bit sampling, false-start rejection, framing/overrun
// detection and a single holding register. Define UART_RECEIVER_PARITY_EN for 8E1 frames.
module uart_byte_receiver #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        uart_receive,
  uart_byte_receiver_if.master        rx_stream,
  output logic                        framing_error,
  output logic                        overrun_error,
  output logic                        parity_error,
  output logic                        busy
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLOCKS_PER_BIT / 2 - 1);

  if (CLOCKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_byte_receiver: CLOCKS_PER_BIT must be >= 4");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t           state_r;
  logic             rx_meta_r;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             byte_done_r;
`ifdef UART_RECEIVER_PARITY_EN
  logic             parity_err_r;
  logic             parity_bad_r;
`endif

  // Two-flop synchroniser for the asynchronous serial line, idle high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= uart_receive;
      rx_s      <= rx_meta_r;
    end
  end

  // Frame state machine; byte_done_r hands a good byte to the holding register one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      byte_done_r   <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parity_err_r  <= 1'b0;
      parity_bad_r  <= 1'b0;
`endif
    end else begin
      byte_done_r   <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parity_err_r  <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          cnt_r     <= '0;
          bit_cnt_r <= 3'd0;
          if (!rx_s) begin
            state_r <= START;
            busy    <= 1'b1;
`ifdef UART_RECEIVER_PARITY_EN
            parity_bad_r <= 1'b0;
`endif
          end
        end
        START: begin
          if (cnt_r == HALF_END) begin
            cnt_r <= '0;
            if (rx_s) begin
              // Line went back high before mid start bit: treat as noise.
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_r <= DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_r == BIT_END) begin
            cnt_r   <= '0;
            shift_r <= {rx_s, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
`ifdef UART_RECEIVER_PARITY_EN
              state_r   <= PARITY;
`else
              state_r   <= STOP;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
`ifdef UART_RECEIVER_PARITY_EN
        PARITY: begin
          if (cnt_r == BIT_END) begin
            cnt_r   <= '0;
            state_r <= STOP;
            // Even parity: the parity bit must equal the XOR of the data bits.
            if (rx_s != (^shift_r)) begin
              parity_err_r <= 1'b1;
              parity_bad_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (cnt_r == BIT_END) begin
            cnt_r <= '0;
            if (rx_s) begin
              state_r <= IDLE;
              busy    <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
              byte_done_r <= ~parity_bad_r;
`else
              byte_done_r <= 1'b1;
`endif
            end else begin
              framing_error <= 1'b1;
              state_r       <= WAIT_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          cnt_r <= '0;
          if (rx_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          bit_cnt_r <= 3'd0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Single holding register toward the consumer; a byte arriving while full is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_stream.data_out       <= 8'h00;
      rx_stream.data_out_valid <= 1'b0;
      overrun_error            <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      if (byte_done_r) begin
        if (!rx_stream.data_out_valid || rx_stream.data_out_ready) begin
          rx_stream.data_out       <= shift_r;
          rx_stream.data_out_valid <= 1'b1;
        end else begin
          overrun_error <= 1'b1;
        end
      end else if (rx_stream.data_out_valid && rx_stream.data_out_ready) begin
        rx_stream.data_out_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RECEIVER_PARITY_EN
  assign parity_error = parity_err_r;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: doc/uart_byte_receiver.md
Name: uart_byte_receiver

Overview:
FPGA-side UART receiver that deserialises 8N1 frames from the host on uart_receive. It presents each received byte on a valid/ready stream toward the harness core. It is the receive end of the host's byte-send routine, mirroring the harness transmitter. It provides mid-bit sampling, false-start rejection, framing/overrun detection and a single output holding register.

Parameters:
CLOCK_FREQUENCY, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate in baud
CLOCKS_PER_BIT, CLOCK_FREQUENCY/BAUD_RATE (localparam), clocks per bit; must be >= 4 (elaboration error otherwise)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (reset=0 resets)
uart_receive  input  1  serial line from host, idle high, asynchronous to clock
data_out  output  8  received byte, LSB = first data bit on the line
data_out_valid  output  1  data_out holds an unconsumed byte
data_out_ready  input  1  consumer accepts the byte when valid && ready
framing_error  output  1  one-cycle pulse: stop bit sampled 0
overrun_error  output  1  one-cycle pulse: byte completed while holding register full
parity_error  output  1  one-cycle pulse: parity mismatch; constant 0 without UART_RECEIVER_PARITY_EN
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, synchroniser flops=1, data_out=0, data_out_valid=0, all error pulses=0, busy=0, bit and cycle counters=0.
- uart_receive passes through a 2-flop synchroniser; all decisions use the synchronised signal rx_s.
- State machine states: IDLE, START, DATA, (PARITY), STOP, WAIT_IDLE.
- IDLE: rx_s=0 -> START with cycle counter cleared.
- START: at count CLOCKS_PER_BIT/2 - 1, sample rx_s.
  - rx_s=1: false start -> IDLE, no error pulse.
  - rx_s=0: -> DATA with counter cleared.
- DATA: sample rx_s every CLOCKS_PER_BIT cycles (mid-bit), shift in LSB-first, 8 samples. After bit 7 -> STOP (or PARITY if enabled).
- STOP: sample after CLOCKS_PER_BIT cycles.
  - rx_s=1: byte complete, -> IDLE in the same cycle, so the next start bit may follow immediately with 1 stop bit.
  - rx_s=0: framing_error pulse, byte dropped, -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then -> IDLE. This handles break conditions without spurious bytes.
- Latency: data_out_valid rises 2 + CLOCKS_PER_BIT/2 + 9*CLOCKS_PER_BIT + 1 cycles after the first clock edge sampling uart_receive low. With CLOCKS_PER_BIT=10 this is 98 cycles.
- Output register:
  - On byte complete with data_out_valid=0: load data_out, set valid next cycle.
  - Valid stays high and data_out stable until valid && ready.
  - Byte complete in the same cycle as valid && ready: new byte loaded, valid stays 1.
  - Byte complete while valid=1 and ready=0: overrun_error pulse, new byte discarded, old byte retained.
- Error pulses are exactly one cycle wide and may coincide with each other only as stated above.
- Counters are sized to clog2(CLOCKS_PER_BIT) bits and never wrap within a state; they are cleared on every state change.

Optional Feature:
Macro UART_RECEIVER_PARITY_EN.
- Defined:
  - Frame is 8E1; PARITY state samples one bit between DATA and STOP.
  - Expected bit = XOR of the 8 data bits (even parity).
  - Mismatch: parity_error pulse at the parity sample, byte dropped; FSM still passes through STOP, with framing check applied.
  - Latency grows by CLOCKS_PER_BIT.
- Not defined: no PARITY state, parity_error tied 0, 8N1 only.

Test Plan:
- CLOCK_FREQUENCY=100, BAUD_RATE=10, ready=1, send 0x11 -> data_out=0x11, valid high exactly 1 cycle, rising 98 cycles after start edge, no error pulses.
- Send 0x22 then 0x33 back-to-back (one stop bit), ready=0 -> valid holds 0x22, overrun_error pulses once at 0x33 completion; raise ready -> 0x22 consumed, valid drops.
- Drive uart_receive low for 3 cycles then high -> no valid, no error, busy returns 0 by cycle 2+5+1; next 0x44 received correctly.
- Send 0x44 with stop bit 0 held low 2 bit-times, then idle -> framing_error pulses once, no valid; following 0x01 received as 0x01.
- Assert reset=0 during data bit 4 of 0x11, release after 3 cycles while line mid-frame, then idle 2 bit-times and send 0x01 -> all outputs 0 during reset, only 0x01 delivered.
- With UART_RECEIVER_PARITY_EN: send 0x01 with parity bit 0 -> parity_error pulse, no valid. Send 0x01 with parity bit 1 -> data_out=0x01 valid after 108 cycles.
